// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder exposing 32 x 8-bit registers, with a W1C interrupt register (HIRQ).
// Define SPI_RESP_STATUS_EN to shift HIRQ out on miso_out during the command byte.
module spi_reg_responder #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       sck_in,
   input  logic       ss_in,
   input  logic       mosi_in,
   output logic       miso_out,
   output logic       int_out,
   input  logic [7:0] irq_set_in,
   output logic       wr_strobe_out,
   output logic [4:0] wr_addr_out,
   output logic [7:0] wr_data_out
);

   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned CNT_W    = 3;

   localparam logic [ADDR_W-1:0] ADDR_CPUCTL = ADDR_W'(16);
   localparam logic [ADDR_W-1:0] ADDR_HIRQ   = ADDR_W'(25);
   localparam logic [ADDR_W-1:0] ADDR_HIEN   = ADDR_W'(26);

   typedef enum logic [1:0] {
      WAIT_SS_HIGH,
      IDLE,
      CMD,
      DATA
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
   logic                   sck_prev_q, ss_prev_q;
   logic                   sck_s, ss_s, mosi_s;
   logic                   sck_rise, sck_fall, ss_fall;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]      rx_q, rx_d, rx_next;
   logic [DATA_W-1:0]      tx_q, tx_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic                   wr_q, wr_d;
   logic                   miso_q, miso_d;
   logic                   int_q, int_d;
   logic                   wr_strobe_q, wr_strobe_d;
   logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]      wr_data_q, wr_data_d;
   logic [DATA_W-1:0]      regs_q [NUM_REGS];
   logic [DATA_W-1:0]      regs_d [NUM_REGS];

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign ss_s     = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign ss_fall  = ~ss_s & ss_prev_q;
   assign rx_next  = {rx_q[DATA_W-2:0], mosi_s};

   // Next-state, shift datapath and register-file update
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      addr_d      = addr_q;
      wr_d        = wr_q;
      miso_d      = miso_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      regs_d      = regs_q;

      case (state_q)
         WAIT_SS_HIGH: begin
            miso_d = 1'b0;
            if (ss_s) state_d = IDLE;
         end
         IDLE: begin
            miso_d = 1'b0;
            if (ss_fall) begin
               state_d   = CMD;
               bit_cnt_d = '0;
               rx_d      = '0;
`ifdef SPI_RESP_STATUS_EN
               miso_d    = regs_q[ADDR_HIRQ][DATA_W-1];
               tx_d      = {regs_q[ADDR_HIRQ][DATA_W-2:0], 1'b0};
`else
               tx_d      = '0;
`endif
            end
         end
         CMD, DATA: begin
            if (ss_s) begin
               // Any partial byte is simply dropped here
               state_d   = IDLE;
               miso_d    = 1'b0;
               bit_cnt_d = '0;
            end else begin
               if (sck_rise) begin
                  rx_d      = rx_next;
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == CNT_W'(7)) begin
                     if (state_q == CMD) begin
                        addr_d  = rx_next[DATA_W-1 -: ADDR_W];
                        wr_d    = rx_next[1];
                        tx_d    = regs_q[rx_next[DATA_W-1 -: ADDR_W]];
                        state_d = DATA;
                     end else begin
                        tx_d = regs_q[addr_q];
                        if (wr_q) begin
                           wr_strobe_d = 1'b1;
                           wr_addr_d   = addr_q;
                           wr_data_d   = rx_next;
                           if (addr_q == ADDR_HIRQ)
                              regs_d[ADDR_HIRQ] = regs_q[ADDR_HIRQ] & ~rx_next;
                           else
                              regs_d[addr_q] = rx_next;
                        end
                     end
                  end
               end
               if (sck_fall) begin
                  miso_d = tx_q[DATA_W-1];
                  tx_d   = {tx_q[DATA_W-2:0], 1'b0};
               end
            end
         end
         default: state_d = WAIT_SS_HIGH;
      endcase

      // Set is applied after the W1C so it wins on a same-cycle collision
      regs_d[ADDR_HIRQ] = regs_d[ADDR_HIRQ] | irq_set_in;
      int_d = ~(regs_d[ADDR_CPUCTL][0] & (|(regs_d[ADDR_HIRQ] & regs_d[ADDR_HIEN])));
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= WAIT_SS_HIGH;
         sck_sync_q  <= '0;
         ss_sync_q   <= '0;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         ss_prev_q   <= 1'b0;
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         addr_q      <= '0;
         wr_q        <= 1'b0;
         miso_q      <= 1'b0;
         int_q       <= 1'b1;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_in};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_in};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
         sck_prev_q  <= sck_s;
         ss_prev_q   <= ss_s;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         addr_q      <= addr_d;
         wr_q        <= wr_d;
         miso_q      <= miso_d;
         int_q       <= int_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         regs_q      <= regs_d;
      end
   end

   // miso is forced low as soon as the initiator deselects, ahead of the synchronizer
   assign miso_out      = miso_q & ~ss_in;
   assign int_out       = int_q;
   assign wr_strobe_out = wr_strobe_q;
   assign wr_addr_out   = wr_addr_q;
   assign wr_data_out   = wr_data_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder: SPI master model plus write/read scoreboards.
module tb_spi_reg_responder;

   localparam int SYNC = 2;
   localparam int HALF = 8;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       sck_in;
   logic       ss_in;
   logic       mosi_in;
   logic       miso_out;
   logic       int_out;
   logic [7:0] irq_set_in;
   logic       wr_strobe_out;
   logic [4:0] wr_addr_out;
   logic [7:0] wr_data_out;

   int errors = 0;
   int checks = 0;

   logic [12:0] exp_wr_q[$];
   logic [12:0] obs_wr_q[$];
   logic [7:0]  exp_rd_q[$];
   logic [7:0]  obs_rd_q[$];

   always #5 clk_in = ~clk_in;

   spi_reg_responder #(.SYNC_STAGES(SYNC)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .sck_in       (sck_in),
      .ss_in        (ss_in),
      .mosi_in      (mosi_in),
      .miso_out     (miso_out),
      .int_out      (int_out),
      .irq_set_in   (irq_set_in),
      .wr_strobe_out(wr_strobe_out),
      .wr_addr_out  (wr_addr_out),
      .wr_data_out  (wr_data_out)
   );

   // Every cycle the strobe is high is logged; a stretched strobe shows up as an extra entry
   always @(negedge clk_in)
      if (wr_strobe_out === 1'b1) obs_wr_q.push_back({wr_addr_out, wr_data_out});

   function automatic logic [7:0] status_byte(input logic [7:0] hirq);
`ifdef SPI_RESP_STATUS_EN
      return hirq;
`else
      return 8'h00 & hirq;
`endif
   endfunction

   task automatic spi_begin();
      ss_in = 1'b0;
      repeat (HALF) @(negedge clk_in);
   endtask

   task automatic spi_end();
      repeat (HALF) @(negedge clk_in);
      ss_in = 1'b1;
      repeat (2 * HALF) @(negedge clk_in);
   endtask

   // Mode-0 byte; hook pulses irq_set_in=0x20 for the single cycle in which the byte commits
   task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit hook,
                           output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < nbits; i++) begin
         mosi_in = tx[7-i];
         repeat (HALF) @(negedge clk_in);
         rx = {rx[6:0], miso_out};
         sck_in = 1'b1;
         for (int c = 0; c < HALF; c++) begin
            @(negedge clk_in);
            if (hook && i == 7 && c == SYNC - 1) irq_set_in = 8'h20;
            if (hook && i == 7 && c == SYNC) begin
               irq_set_in = 8'h00;
               checks++;
               if (wr_strobe_out !== 1'b1) begin
                  errors++;
                  $display("FAIL strobe_timing: wr_strobe_out=%b, required 1", wr_strobe_out);
               end
            end
         end
         sck_in = 1'b0;
      end
   endtask

   task automatic spi_write(input logic [4:0] a, input logic [7:0] d, input bit hook);
      logic [7:0] rx;
      spi_begin();
      spi_byte({a, 3'b010}, 8, 1'b0, rx);
      spi_byte(d, 8, hook, rx);
      spi_end();
   endtask

   task automatic spi_read(input logic [4:0] a, input int nbytes);
      logic [7:0] rx;
      spi_begin();
      spi_byte({a, 3'b000}, 8, 1'b0, rx);
      obs_rd_q.push_back(rx);
      for (int n = 0; n < nbytes; n++) begin
         spi_byte(8'h00, 8, 1'b0, rx);
         obs_rd_q.push_back(rx);
      end
      spi_end();
   endtask

   task automatic pulse_irq(input logic [7:0] v);
      @(negedge clk_in);
      irq_set_in = v;
      @(negedge clk_in);
      irq_set_in = 8'h00;
   endtask

   task automatic test_reset();
      rst_in = 1'b0; sck_in = 1'b0; ss_in = 1'b1; mosi_in = 1'b0; irq_set_in = 8'h00;
      repeat (3) @(negedge clk_in);
      checks += 5;
      if (miso_out !== 1'b0) begin errors++; $display("FAIL rst_miso: got %b, required 0", miso_out); end
      if (int_out !== 1'b1) begin errors++; $display("FAIL rst_int: got %b, required 1", int_out); end
      if (wr_strobe_out !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b, required 0", wr_strobe_out); end
      if (wr_addr_out !== 5'd0) begin errors++; $display("FAIL rst_addr: got %0d, required 0", wr_addr_out); end
      if (wr_data_out !== 8'h00) begin errors++; $display("FAIL rst_data: got %h, required 00", wr_data_out); end
      rst_in = 1'b1;
      repeat (HALF) @(negedge clk_in);
   endtask

   task automatic test_write();
      logic [12:0] e, o;
      exp_wr_q.push_back({5'd20, 8'h01});
      spi_write(5'd20, 8'h01, 1'b0);
      checks++;
      if (obs_wr_q.size() != exp_wr_q.size()) begin
         errors++; $display("FAIL write_count: got %0d, required %0d", obs_wr_q.size(), exp_wr_q.size());
      end
      while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
         e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL write_entry: got %h, required %h", o, e); end
      end
      exp_wr_q.delete(); obs_wr_q.delete();
   endtask

   task automatic test_read();
      logic [7:0] e, o;
      exp_rd_q.push_back(status_byte(8'h00));
      exp_rd_q.push_back(8'h01);
      exp_rd_q.push_back(8'h01);
      spi_read(5'd20, 2);
      while (exp_rd_q.size() > 0) begin
         e = exp_rd_q.pop_front(); o = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : 8'hxx; checks++;
         if (o !== e) begin errors++; $display("FAIL read_reg20: got %h, required %h", o, e); end
      end
      obs_rd_q.delete();
   endtask

   task automatic test_interrupt();
      logic [12:0] e, o;
      logic [7:0]  re, ro;
      exp_wr_q.push_back({5'd16, 8'h01});
      exp_wr_q.push_back({5'd26, 8'h20});
      spi_write(5'd16, 8'h01, 1'b0);
      spi_write(5'd26, 8'h20, 1'b0);
      checks++;
      if (int_out !== 1'b1) begin errors++; $display("FAIL int_before_irq: got %b, required 1", int_out); end
      pulse_irq(8'h20);
      checks++;
      if (int_out !== 1'b0) begin errors++; $display("FAIL int_after_irq: got %b, required 0", int_out); end
      exp_rd_q.push_back(status_byte(8'h20));
      exp_rd_q.push_back(8'h20);
      spi_read(5'd25, 1);
      exp_wr_q.push_back({5'd25, 8'h20});
      spi_write(5'd25, 8'h20, 1'b0);
      checks++;
      if (int_out !== 1'b1) begin errors++; $display("FAIL int_after_w1c: got %b, required 1", int_out); end
      exp_rd_q.push_back(status_byte(8'h00));
      exp_rd_q.push_back(8'h00);
      spi_read(5'd25, 1);
      while (exp_rd_q.size() > 0) begin
         re = exp_rd_q.pop_front(); ro = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : 8'hxx; checks++;
         if (ro !== re) begin errors++; $display("FAIL read_hirq: got %h, required %h", ro, re); end
      end
      checks++;
      if (obs_wr_q.size() != exp_wr_q.size()) begin
         errors++; $display("FAIL int_write_count: got %0d, required %0d", obs_wr_q.size(), exp_wr_q.size());
      end
      while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
         e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL int_write_entry: got %h, required %h", o, e); end
      end
      exp_wr_q.delete(); obs_wr_q.delete(); obs_rd_q.delete();
   endtask

   task automatic test_simultaneous();
      logic [12:0] e, o;
      logic [7:0]  re, ro;
      pulse_irq(8'h20);
      exp_wr_q.push_back({5'd25, 8'h20});
      spi_write(5'd25, 8'h20, 1'b1);
      checks++;
      if (int_out !== 1'b0) begin errors++; $display("FAIL sim_int: got %b, required 0", int_out); end
      exp_rd_q.push_back(status_byte(8'h20));
      exp_rd_q.push_back(8'h20);
      spi_read(5'd25, 1);
      while (exp_rd_q.size() > 0) begin
         re = exp_rd_q.pop_front(); ro = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : 8'hxx; checks++;
         if (ro !== re) begin errors++; $display("FAIL sim_hirq: got %h, required %h", ro, re); end
      end
      checks++;
      if (obs_wr_q.size() != exp_wr_q.size()) begin
         errors++; $display("FAIL sim_write_count: got %0d, required %0d", obs_wr_q.size(), exp_wr_q.size());
      end
      while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
         e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL sim_write_entry: got %h, required %h", o, e); end
      end
      exp_wr_q.delete(); obs_wr_q.delete(); obs_rd_q.delete();
   endtask

   task automatic test_abort();
      logic [12:0] e, o;
      logic [7:0]  re, ro, rx;
      exp_wr_q.push_back({5'd3, 8'h5A});
      spi_write(5'd3, 8'h5A, 1'b0);
      spi_begin();
      spi_byte(8'h1A, 8, 1'b0, rx);
      spi_byte(8'hFF, 5, 1'b0, rx);
      spi_end();
      exp_rd_q.push_back(status_byte(8'h20));
      exp_rd_q.push_back(8'h5A);
      spi_read(5'd3, 1);
      while (exp_rd_q.size() > 0) begin
         re = exp_rd_q.pop_front(); ro = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : 8'hxx; checks++;
         if (ro !== re) begin errors++; $display("FAIL abort_reg3: got %h, required %h", ro, re); end
      end
      checks++;
      if (obs_wr_q.size() != exp_wr_q.size()) begin
         errors++; $display("FAIL abort_write_count: got %0d, required %0d", obs_wr_q.size(), exp_wr_q.size());
      end
      while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
         e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL abort_write_entry: got %h, required %h", o, e); end
      end
      exp_wr_q.delete(); obs_wr_q.delete(); obs_rd_q.delete();
   endtask

   task automatic test_reset_mid();
      logic [12:0] e, o;
      logic [7:0]  re, ro, rx;
      spi_begin();
      spi_byte(8'h3A, 8, 1'b0, rx);
      spi_byte(8'hC3, 4, 1'b0, rx);
      rst_in = 1'b0;
      repeat (3) @(negedge clk_in);
      checks += 5;
      if (miso_out !== 1'b0) begin errors++; $display("FAIL mid_rst_miso: got %b, required 0", miso_out); end
      if (int_out !== 1'b1) begin errors++; $display("FAIL mid_rst_int: got %b, required 1", int_out); end
      if (wr_strobe_out !== 1'b0) begin errors++; $display("FAIL mid_rst_strobe: got %b, required 0", wr_strobe_out); end
      if (wr_addr_out !== 5'd0) begin errors++; $display("FAIL mid_rst_addr: got %0d, required 0", wr_addr_out); end
      if (wr_data_out !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h, required 00", wr_data_out); end
      rst_in = 1'b1;
      repeat (4) @(negedge clk_in);
      spi_byte(8'h3A, 8, 1'b0, rx);
      spi_byte(8'h99, 8, 1'b0, rx);
      spi_byte(8'h66, 8, 1'b0, rx);
      spi_end();
      checks++;
      if (obs_wr_q.size() != 0) begin
         errors++; $display("FAIL mid_rst_ignored: got %0d strobes, required 0", obs_wr_q.size());
      end
      obs_wr_q.delete();
      exp_wr_q.push_back({5'd7, 8'h77});
      spi_write(5'd7, 8'h77, 1'b0);
      exp_rd_q.push_back(status_byte(8'h00));
      exp_rd_q.push_back(8'h77);
      spi_read(5'd7, 1);
      exp_rd_q.push_back(status_byte(8'h00));
      exp_rd_q.push_back(8'h00);
      spi_read(5'd20, 1);
      while (exp_rd_q.size() > 0) begin
         re = exp_rd_q.pop_front(); ro = (obs_rd_q.size() > 0) ? obs_rd_q.pop_front() : 8'hxx; checks++;
         if (ro !== re) begin errors++; $display("FAIL mid_rst_read: got %h, required %h", ro, re); end
      end
      checks++;
      if (obs_wr_q.size() != exp_wr_q.size()) begin
         errors++; $display("FAIL mid_rst_write_count: got %0d, required %0d", obs_wr_q.size(), exp_wr_q.size());
      end
      while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
         e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL mid_rst_write_entry: got %h, required %h", o, e); end
      end
      exp_wr_q.delete(); obs_wr_q.delete(); obs_rd_q.delete();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_interrupt();
      test_simultaneous();
      test_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_reg_responder.md
SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for sck_in, ss_in and mosi_in (legal range 2..4).
REQ-002 SHALL have port clk_in, input, 1 bit: system clock; all state is in this domain, and its frequency is at least 8x the sck_in frequency.
REQ-003 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port sck_in, input, 1 bit: SPI clock from the initiator, mode 0 (CPOL=0, CPHA=0), MSB first.
REQ-005 SHALL have port ss_in, input, 1 bit: slave select, active-low.
REQ-006 SHALL have port mosi_in, input, 1 bit: initiator-to-responder data.
REQ-007 SHALL have port miso_out, output, 1 bit: responder-to-initiator data, driven 0 whenever ss_in is high.
REQ-008 SHALL have port int_out, output, 1 bit: interrupt to the initiator, active-low.
REQ-009 SHALL have port irq_set_in, input, 8 bits: per-bit one-cycle requests to set HIRQ bits.
REQ-010 SHALL have port wr_strobe_out, output, 1 bit: one-cycle pulse for each committed register write.
REQ-011 SHALL have port wr_addr_out, output, 5 bits: address of the committed write.
REQ-012 SHALL have port wr_data_out, output, 8 bits: data of the committed write.

Function
REQ-013 SHALL contain 32 x 8-bit registers; special addresses: CPUCTL=16 (bit0 = IE), HIRQ=25, HIEN=26.
REQ-014 SHALL sample mosi_in on each synchronized sck_in rising edge and update miso_out on each synchronized sck_in falling edge.
REQ-015 SHALL treat the first byte after ss_in falls as the command byte: bits[7:3] are the address, bit1 = 1 means write, and bits 2 and 0 are ignored.
REQ-016 SHALL have states WAIT_SS_HIGH, IDLE, CMD and DATA, with transitions WAIT_SS_HIGH->IDLE on ss_in high, IDLE->CMD on ss_in falling edge, CMD->DATA after the 8th sck rising edge, and DATA->DATA on each further byte.
REQ-017 SHALL return from any of CMD or DATA to IDLE within 1 clk_in cycle of the synchronized ss_in going high.
REQ-018 SHALL, in a write transaction, commit each complete data byte to the addressed register, with wr_strobe_out high for exactly 1 cycle, 1 clk_in cycle after the 8th synchronized sck rising edge of that byte.
REQ-019 SHALL, in a read transaction, shift out the addressed register, latched at the end of the command byte and re-latched at each data-byte boundary, MSB first; the first data bit is presented after the 8th sck falling edge of the command byte.
REQ-020 SHALL NOT auto-increment the address: multi-byte transfers repeatedly access the same register, as in FIFO access.
REQ-021 SHALL discard a partial byte (fewer than 8 bits) when ss_in rises, with no register update and no wr_strobe_out.
REQ-022 SHALL implement HIRQ as write-1-to-clear; any bit asserted in irq_set_in sets the corresponding HIRQ bit.
REQ-023 SHALL give set priority over clear when irq_set_in and a write-1-to-clear hit the same HIRQ bit in the same cycle.
REQ-024 SHALL drive int_out low exactly when CPUCTL[0]=1 and (HIRQ & HIEN) != 0, registered with 1-cycle latency.

Reset
REQ-025 SHALL, while rst_in is low, force miso_out=0, int_out=1, wr_strobe_out=0, wr_addr_out=0, wr_data_out=0, all registers to 0, the shift counters to 0, and the state to WAIT_SS_HIGH.
REQ-026 SHALL, on release of reset in the middle of a transaction, ignore all traffic until ss_in has been seen high.

Configuration
REQ-027 SHALL, when macro SPI_RESP_STATUS_EN is defined, shift the current HIRQ value out on miso_out during the command byte, with the MSB valid within 2 clk_in cycles of the synchronized ss_in falling edge.
REQ-028 SHALL, when SPI_RESP_STATUS_EN is undefined, hold miso_out at 0 throughout the command byte; all other behaviour is unchanged.

Verification
REQ-029 SHALL cover a write: command 0xA2 followed by data 0x01 -> register 20 = 0x01, one wr_strobe_out pulse with wr_addr_out=20 and wr_data_out=0x01.
REQ-030 SHALL cover a read: after the write above, command 0xA0 followed by 8 dummy clocks -> miso_out bits 0,0,0,0,0,0,0,1.
REQ-031 SHALL cover interrupts: write CPUCTL=0x01 and HIEN=0x20, then pulse irq_set_in=0x20 -> int_out low 1 cycle later; then write HIRQ=0x20 -> int_out high.
REQ-032 SHALL cover the simultaneous case: irq_set_in=0x20 in the same cycle as the write-1-to-clear of HIRQ=0x20 -> HIRQ stays 0x20 and int_out stays low.
REQ-033 SHALL cover an aborted byte: ss_in raised after 5 data bits of a write to register 3 -> register 3 unchanged and no wr_strobe_out.
REQ-034 SHALL cover reset mid-transfer: rst_in pulsed low during a data byte with ss_in held low -> outputs at reset values, and the next write is accepted only after ss_in goes high and then low again.
